loteria_multi: RTL and testbench

Parametrised lottery-entry engine, the next generation of the board's single-ticket 5-digit game. It collects a `DIGITS`-long BCD guess from a keypad/switch bank and scores it against a programmable secret by longest run of positionally matching digits. It awards one of three prize tiers, counts wins, and drives one seven-segment display per digit plus a prize display. It sits directly behind the debounced board keys, and its outputs go straight to the HEX/LED pins.

---
 rtl/loteria_multi_pkg.sv | 20 ++
 rtl/loteria_multi_if.sv | 27 ++
 rtl/loteria_multi_seg7.sv | 18 +
 rtl/loteria_multi.sv | 186 ++++++++++++++++++
 tb/tb_loteria_multi.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loteria_multi_pkg.sv
// Shared types and seven-segment constants for the lottery-entry engine.
// Segment bit order is g,f,e,d,c,b,a (bit 6 down to bit 0), active low.
package loteria_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        WAIT_FIN,
        EVAL,
        SHOW
    } state_e;

    localparam logic [6:0] SEG_DIG [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_P    = 7'b0001100;

endpackage

// File: rtl/loteria_multi_if.sv
// Keypad inputs and display/result outputs of the lottery engine.
// The master side drives the keys; the slave side is the engine.
interface loteria_multi_if #(
    parameter int DIGITS = 5
);
    logic [3:0]          num;
    logic                insert;
    logic                finish;
    logic                prog;
    logic [7*DIGITS-1:0] seg_digits;
    logic [6:0]          seg_prize;
    logic                win;
    logic [1:0]          prize;
    logic                reject;
    logic [7:0]          wins;
    logic                busy;

    modport master (
        output num, insert, finish, prog,
        input  seg_digits, seg_prize, win, prize, reject, wins, busy
    );

    modport slave (
        input  num, insert, finish, prog,
        output seg_digits, seg_prize, win, prize, reject, wins, busy
    );
endinterface

// File: rtl/loteria_multi_seg7.sv
// BCD to active-low seven-segment decoder with a forced-dash override.
// Values above 9 also render as a dash.
module seg7_dec
    import loteria_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (!dash_i && (val_i <= 4'd9)) begin
            seg_o = SEG_DIG[val_i];
        end
    end

endmodule

// File: rtl/loteria_multi.sv
// Lottery-entry engine: collects a BCD guess, scores it by longest run of
// positional matches against a programmable secret, and drives the displays.
module loteria_multi
    import loteria_pkg::*;
#(
    parameter int                  DIGITS = 5,
    parameter logic [4*DIGITS-1:0] SECRET = 20'h50967,
    parameter int                  RUN2   = DIGITS - 1,
    parameter int                  RUN3   = DIGITS - 2
) (
    input  logic            clk,
    input  logic            reset,
    loteria_multi_if.slave  bus
);

    // states: IDLE wait | ENTRY collecting | WAIT_FIN full, await finish | EVAL score | SHOW result
    localparam int             IW      = $clog2(DIGITS + 1);
    localparam logic [IW-1:0]  RUN_ALL = IW'(DIGITS);
    localparam logic [IW-1:0]  RUN_P2  = IW'(RUN2);
    localparam logic [IW-1:0]  RUN_P3  = IW'(RUN3);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   mode_q, mode_d;
    logic [DIGITS-1:0][3:0] guess_q, guess_d;
    logic [DIGITS-1:0][3:0] secret_q, secret_d;
    logic [1:0]             prize_q, prize_d;
    logic                   win_q, win_d;
    logic                   reject_q, reject_d;
    logic [7:0]             wins_q, wins_d;
    logic                   insert_dly_q, finish_dly_q;

    logic                   ins_ev, fin_ev, num_ok;
    logic [IW-1:0]          run, cur;
    logic [1:0]             tier;
    logic [7*DIGITS-1:0]    seg_all;

    assign ins_ev = bus.insert & ~insert_dly_q;
    assign fin_ev = bus.finish & ~finish_dly_q;
    assign num_ok = (bus.num <= 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            mode_q       <= 1'b0;
            guess_q      <= '0;
            secret_q     <= SECRET;
            prize_q      <= 2'd0;
            win_q        <= 1'b0;
            reject_q     <= 1'b0;
            wins_q       <= 8'd0;
            insert_dly_q <= 1'b0;
            finish_dly_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            guess_q      <= guess_d;
            secret_q     <= secret_d;
            prize_q      <= prize_d;
            win_q        <= win_d;
            reject_q     <= reject_d;
            wins_q       <= wins_d;
            insert_dly_q <= bus.insert;
            finish_dly_q <= bus.finish;
        end
    end

    // Digit i of guess/secret lives in element DIGITS-1-i (digit 0 is the MS nibble).
    always_comb begin
        cur = '0;
        run = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (guess_q[i] == secret_q[i]) begin
                cur = cur + IW'(1);
            end else begin
                cur = '0;
            end
            if (cur > run) begin
                run = cur;
            end
        end
    end

    always_comb begin
        tier = 2'd0;
        if (run == RUN_ALL) begin
            tier = 2'd1;
        end else if (run >= RUN_P2) begin
            tier = 2'd2;
        end else if (run >= RUN_P3) begin
            tier = 2'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        guess_d  = guess_q;
        secret_d = secret_q;
        prize_d  = prize_q;
        win_d    = win_q;
        wins_d   = wins_q;
        reject_d = 1'b0;

        unique case (state_q)
            IDLE, SHOW: begin
                if (ins_ev) begin
                    if (num_ok) begin
                        mode_d              = bus.prog;
                        guess_d[DIGITS-1]   = bus.num;
                        idx_d               = IW'(1);
                        state_d             = ENTRY;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ENTRY: begin
                if (ins_ev) begin
                    if (num_ok) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (idx_q == IW'(i)) begin
                                guess_d[DIGITS-1-i] = bus.num;
                            end
                        end
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = WAIT_FIN;
                        end
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            WAIT_FIN: begin
                // a simultaneous insert swallows the finish
                if (fin_ev && !ins_ev) begin
                    if (mode_q) begin
                        secret_d = guess_q;
                        idx_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                prize_d = tier;
                win_d   = (tier != 2'd0);
                if (tier != 2'd0) begin
                    wins_d = wins_q + 8'd1;
                end
                state_d = SHOW;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic shown;
        assign shown = (IW'(g) < idx_q) && !mode_q;
        seg7_dec u_dec (
            .val_i  (guess_q[DIGITS-1-g]),
            .dash_i (!shown),
            .seg_o  (seg_all[7*g +: 7])
        );
    end

    seg7_dec u_prize (
        .val_i  ({2'b00, prize_q}),
        .dash_i (1'b0),
        .seg_o  (bus.seg_prize)
    );

    assign bus.seg_digits = seg_all;
    assign bus.win        = win_q;
    assign bus.prize      = prize_q;
    assign bus.reject     = reject_q;
    assign bus.wins       = wins_q;
    assign bus.busy       = (state_q == ENTRY) || (state_q == WAIT_FIN);

endmodule

// File: tb/tb_loteria_multi.sv
// Directed bench for loteria_multi: a ticket-level model is checked against
// the DUT every cycle, plus hand-computed literal checkpoints.
module tb_loteria_multi;

    localparam int DIGITS = 5;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] SEGTAB [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam int PH_IDLE = 0, PH_ENTRY = 1, PH_WAIT = 2, PH_EVAL = 3, PH_SHOW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    loteria_multi_if #(.DIGITS(DIGITS)) bus ();

    loteria_multi #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // ticket-level model
    int m_phase;
    int m_cnt;
    bit m_prog;
    int m_guess [DIGITS];
    int m_secret [DIGITS];
    int m_prize;
    bit m_win;
    int m_wins;
    bit m_reject;
    bit m_ins_prev, m_fin_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void reset_model();
        int sec;
        sec = 'h50967;
        for (int i = 0; i < DIGITS; i++) begin
            m_secret[i] = (sec >> (4 * (DIGITS - 1 - i))) & 15;
            m_guess[i] = 0;
        end
        m_phase = PH_IDLE; m_cnt = 0; m_prog = 0;
        m_prize = 0; m_win = 0; m_wins = 0; m_reject = 0;
        m_ins_prev = 0; m_fin_prev = 0;
    endfunction

    function automatic int longest_run();
        int best, c;
        best = 0; c = 0;
        for (int i = 0; i < DIGITS; i++) begin
            c = (m_guess[i] == m_secret[i]) ? c + 1 : 0;
            if (c > best) best = c;
        end
        return best;
    endfunction

    function automatic int prize_of(input int r);
        if (r == DIGITS) return 1;
        if (r >= DIGITS - 1) return 2;
        if (r >= DIGITS - 2) return 3;
        return 0;
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_seg();
        logic [7*DIGITS-1:0] e;
        for (int i = 0; i < DIGITS; i++)
            e[7*i +: 7] = (i < m_cnt && !m_prog) ? SEGTAB[m_guess[i]] : DASH;
        return e;
    endfunction

    always @(posedge clk) begin
        bit iev, fev;
        if (reset) begin
            reset_model();
        end else begin
            iev = bus.insert && !m_ins_prev;
            fev = bus.finish && !m_fin_prev;
            m_ins_prev = bus.insert;
            m_fin_prev = bus.finish;
            m_reject = 0;
            case (m_phase)
                PH_IDLE, PH_SHOW: if (iev) begin
                    if (bus.num <= 9) begin
                        m_prog = bus.prog; m_guess[0] = int'(bus.num); m_cnt = 1; m_phase = PH_ENTRY;
                    end else m_reject = 1;
                end
                PH_ENTRY: if (iev) begin
                    if (bus.num <= 9) begin
                        m_guess[m_cnt] = int'(bus.num); m_cnt++;
                        if (m_cnt == DIGITS) m_phase = PH_WAIT;
                    end else m_reject = 1;
                end
                PH_WAIT: if (fev && !iev) begin
                    if (m_prog) begin
                        m_secret = m_guess; m_phase = PH_IDLE;
                    end else m_phase = PH_EVAL;
                end
                PH_EVAL: begin
                    m_prize = prize_of(longest_run());
                    m_win = (m_prize != 0);
                    if (m_win) m_wins = (m_wins + 1) % 256;
                    m_phase = PH_SHOW;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("seg_digits", bus.seg_digits, exp_seg());
            check("seg_prize", bus.seg_prize, SEGTAB[m_prize]);
            check("win", bus.win, m_win);
            check("prize", bus.prize, m_prize);
            check("reject", bus.reject, m_reject);
            check("wins", bus.wins, m_wins);
            check("busy", bus.busy, (m_phase == PH_ENTRY || m_phase == PH_WAIT));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_insert(input int d, input int hold);
        bus.num = 4'(d);
        bus.insert = 1'b1;
        tick(hold);
        bus.insert = 1'b0;
        tick(1);
    endtask

    task automatic press_finish();
        bus.finish = 1'b1;
        tick(1);
        bus.finish = 1'b0;
        tick(1);
    endtask

    task automatic play(input logic [19:0] t, input bit p, input int hold);
        bus.prog = p;
        press_insert(int'(t[19:16]), hold);
        bus.prog = 1'b0;
        for (int i = 1; i < DIGITS; i++) press_insert(int'(t[4*(DIGITS-1-i) +: 4]), hold);
        press_finish();
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg"}, bus.seg_digits, {DIGITS{DASH}});
        check({tag, "_segp"}, bus.seg_prize, 7'b1000000);
        check({tag, "_prize"}, bus.prize, 2'd0);
        check({tag, "_win"}, bus.win, 1'b0);
        check({tag, "_wins"}, bus.wins, 8'd0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_reject"}, bus.reject, 1'b0);
    endtask

    initial begin
        bus.num = 4'd0; bus.insert = 1'b0; bus.finish = 1'b0; bus.prog = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check_reset_vals("rst");

        play(20'h50967, 1'b0, 3);
        check("t1_prize", bus.prize, 2'd1);
        check("t1_win", bus.win, 1'b1);
        check("t1_wins", bus.wins, 8'd1);
        check("t1_segp", bus.seg_prize, 7'b1111001);

        play(20'h10967, 1'b0, 1);
        check("t2_prize", bus.prize, 2'd2);
        play(20'h50912, 1'b0, 1);
        check("t3_prize", bus.prize, 2'd3);
        play(20'h33333, 1'b0, 1);
        check("t4_prize", bus.prize, 2'd0);
        check("t4_win", bus.win, 1'b0);
        check("t4_wins", bus.wins, 8'd3);

        // reject while at index 2, then a premature finish
        press_insert(1, 1);
        press_insert(2, 1);
        bus.num = 4'd12;
        bus.insert = 1'b1;
        tick(1);
        check("rej_pulse", bus.reject, 1'b1);
        tick(1);
        check("rej_end", bus.reject, 1'b0);
        bus.insert = 1'b0;
        tick(1);
        check("rej_seg", bus.seg_digits, {DASH, DASH, DASH, 7'b0100100, 7'b1111001});
        press_finish();
        check("early_fin_busy", bus.busy, 1'b1);
        press_insert(3, 1);
        press_insert(4, 1);
        press_insert(5, 1);
        press_finish();
        tick(2);
        check("t5_prize", bus.prize, 2'd0);

        // reprogram the secret to 12345
        play(20'h12345, 1'b1, 1);
        check("prog_seg", bus.seg_digits, {DIGITS{DASH}});
        check("prog_busy", bus.busy, 1'b0);
        check("prog_prize", bus.prize, 2'd0);
        play(20'h12345, 1'b0, 1);
        check("t6_prize", bus.prize, 2'd1);
        check("t6_wins", bus.wins, 8'd4);
        play(20'h50967, 1'b0, 1);
        check("t7_prize", bus.prize, 2'd0);

        // long hold stores one digit; insert+finish together is no evaluation
        press_insert(1, 10);
        check("hold_seg", bus.seg_digits, {DASH, DASH, DASH, DASH, 7'b1111001});
        press_insert(2, 1);
        press_insert(3, 1);
        press_insert(4, 1);
        press_insert(7, 1);
        bus.num = 4'd3;
        bus.insert = 1'b1;
        bus.finish = 1'b1;
        tick(1);
        bus.insert = 1'b0;
        bus.finish = 1'b0;
        tick(3);
        check("simul_busy", bus.busy, 1'b1);
        check("simul_prize", bus.prize, 2'd0);
        press_finish();
        tick(2);
        check("t8_prize", bus.prize, 2'd2);
        check("t8_wins", bus.wins, 8'd5);

        // reset during a pending reprogram
        bus.prog = 1'b1;
        press_insert(9, 1);
        bus.prog = 1'b0;
        press_insert(9, 1);
        press_insert(9, 1);
        do_reset();
        check_reset_vals("midrst");
        play(20'h50967, 1'b0, 1);
        check("t9_prize", bus.prize, 2'd1);

        // wins counter wrap
        do_reset();
        for (int n = 0; n < 255; n++) play(20'h50967, 1'b0, 1);
        check("wins_255", bus.wins, 8'd255);
        play(20'h50967, 1'b0, 1);
        check("wins_wrap", bus.wins, 8'd0);
        check("wrap_win", bus.win, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
